// File: rtl/mfp_irq_ctrl_if.sv
// CPU-side register/handshake bundle of the MFP interrupt controller.
// Master is the CPU interface logic; slave is the controller.
interface mfp_irq_ctrl_if #(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned CW       = $clog2(CHANNELS)
);
    logic [CHANNELS-1:0] enable;
    logic [CHANNELS-1:0] mask;
    logic [CHANNELS-1:0] clr_pend;
    logic [CHANNELS-1:0] clr_isr;
    logic                sei;
    logic                iack;
    logic                irq;
    logic [CW-1:0]       irq_num;
    logic [CHANNELS-1:0] ipr;
    logic [CHANNELS-1:0] isr;

    modport master (
        output enable, mask, clr_pend, clr_isr, sei, iack,
        input  irq, irq_num, ipr, isr
    );

    modport slave (
        input  enable, mask, clr_pend, clr_isr, sei, iack,
        output irq, irq_num, ipr, isr
    );
endinterface

// File: rtl/mfp_irq_ctrl.sv
// N-channel MFP interrupt controller: edge detect, pending/in-service registers,
// priority encode with in-service blocking and acknowledge handshake.
module mfp_irq_ctrl #(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned CW       = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] src,
    input  logic [CHANNELS-1:0] edge_pol,
    mfp_irq_ctrl_if.slave       bus
);
    logic [CHANNELS-1:0] src_d;
    logic                armed;
    logic [CHANNELS-1:0] ipr_q, ipr_d;
    logic [CHANNELS-1:0] isr_q, isr_d;
    logic [CHANNELS-1:0] edge_det;
    logic [CHANNELS-1:0] block;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] hit;
    logic [CW-1:0]       num;
    logic                any_req;

    // Edge detection stays off until src_d has captured a real sample after reset.
    assign edge_det = {CHANNELS{armed}} & (src_d ^ src) & ~(src ^ edge_pol);

    always_comb begin
        block = '0;
        if (bus.sei) begin
            // Channel j is blocked when any channel at or above j is in service.
            for (int j = 0; j < CHANNELS; j++) begin
                block[j] = |(isr_q >> j);
            end
        end
        req = ipr_q & bus.mask & ~block;
    end

    always_comb begin
        num = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (req[i]) begin
                num = CW'(i);
            end
        end
        any_req = |req;
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i] = bus.iack && any_req && (num == CW'(i));
        end
    end

    always_comb begin
        ipr_d = ipr_q;
        isr_d = isr_q;
        for (int i = 0; i < CHANNELS; i++) begin
            // CPU clear beats a new edge, which beats the acknowledge clear.
            if (!bus.enable[i] || bus.clr_pend[i]) begin
                ipr_d[i] = 1'b0;
            end else if (edge_det[i]) begin
                ipr_d[i] = 1'b1;
            end else if (hit[i]) begin
                ipr_d[i] = 1'b0;
            end

            if (!bus.sei || bus.clr_isr[i]) begin
                isr_d[i] = 1'b0;
            end else if (hit[i]) begin
                isr_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_d <= '0;
            armed <= 1'b0;
            ipr_q <= '0;
            isr_q <= '0;
        end else begin
            src_d <= src;
            armed <= 1'b1;
            ipr_q <= ipr_d;
            isr_q <= isr_d;
        end
    end

    assign bus.irq     = any_req;
    assign bus.irq_num = num;
    assign bus.ipr     = ipr_q;
    assign bus.isr     = isr_q;
endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Directed, table-driven bench for mfp_irq_ctrl (16 channels).
module tb_mfp_irq_ctrl;
    localparam int unsigned N = 16;

    typedef struct {
        logic [N-1:0] src;
        logic [N-1:0] pol;
        logic [N-1:0] en;
        logic [N-1:0] msk;
        logic [N-1:0] cp;
        logic [N-1:0] ci;
        logic         sei;
        logic         iack;
        logic [N-1:0] e_ipr;
        logic [N-1:0] e_isr;
        logic         e_irq;
        logic [3:0]   e_num;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] src;
    logic [N-1:0] edge_pol;
    int           checks = 0;
    int           failures = 0;
    vec_t         tbl[$];

    mfp_irq_ctrl_if #(.CHANNELS(N)) bus ();

    mfp_irq_ctrl #(.CHANNELS(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .src      (src),
        .edge_pol (edge_pol),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [N-1:0] s, logic [N-1:0] p, logic [N-1:0] en,
                                logic [N-1:0] m, logic [N-1:0] cp, logic [N-1:0] ci,
                                logic sei, logic iack, logic [N-1:0] e_ipr,
                                logic [N-1:0] e_isr, logic e_irq, logic [3:0] e_num);
        vec_t v;
        v.src = s;  v.pol = p;   v.en = en;       v.msk = m;
        v.cp = cp;  v.ci = ci;   v.sei = sei;     v.iack = iack;
        v.e_ipr = e_ipr; v.e_isr = e_isr; v.e_irq = e_irq; v.e_num = e_num;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(string tag, int idx, logic [N-1:0] e_ipr, logic [N-1:0] e_isr,
                             logic e_irq, logic [3:0] e_num);
        chk({tag, ".ipr"}, idx, 32'(bus.ipr), 32'(e_ipr));
        chk({tag, ".isr"}, idx, 32'(bus.isr), 32'(e_isr));
        chk({tag, ".irq"}, idx, 32'(bus.irq), 32'(e_irq));
        chk({tag, ".irq_num"}, idx, 32'(bus.irq_num), 32'(e_num));
    endtask

    task automatic drive(vec_t v);
        src          = v.src;
        edge_pol     = v.pol;
        bus.enable   = v.en;
        bus.mask     = v.msk;
        bus.clr_pend = v.cp;
        bus.clr_isr  = v.ci;
        bus.sei      = v.sei;
        bus.iack     = v.iack;
    endtask

    initial begin
        // src, pol, en, mask, clr_pend, clr_isr, sei, iack | ipr, isr, irq, num
        // Reset release with src[0] high, then src[0] 1->0->1, acked.
        tbl.push_back(mk('h0001, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0000, 0, 0, 0));
        tbl.push_back(mk('h0001, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0000, 0, 0, 0));
        tbl.push_back(mk('h0000, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0000, 0, 0, 0));
        tbl.push_back(mk('h0001, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0001, 0, 1, 0));
        tbl.push_back(mk('h0001, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 1, 'h0000, 0, 0, 0));
        // Falling-edge polarity on ch3, then again with ch3 disabled, then static pol change.
        tbl.push_back(mk('h0009, 'hFFF7, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0000, 0, 0, 0));
        tbl.push_back(mk('h0001, 'hFFF7, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0008, 0, 1, 3));
        tbl.push_back(mk('h0001, 'hFFF7, 'hFFFF, 'hFFFF, 0, 0, 0, 1, 'h0000, 0, 0, 0));
        tbl.push_back(mk('h0009, 'hFFF7, 'hFFF7, 'hFFFF, 0, 0, 0, 0, 'h0000, 0, 0, 0));
        tbl.push_back(mk('h0001, 'hFFF7, 'hFFF7, 'hFFFF, 0, 0, 0, 0, 'h0000, 0, 0, 0));
        tbl.push_back(mk('h0001, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0000, 0, 0, 0));
        // Simultaneous edges on ch2 and ch9, two acknowledges.
        tbl.push_back(mk('h0205, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0204, 0, 1, 9));
        tbl.push_back(mk('h0205, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 1, 'h0004, 0, 1, 2));
        tbl.push_back(mk('h0205, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 1, 'h0000, 0, 0, 0));
        // Software EOI: ch5 in service blocks ch4, ch7 nests.
        tbl.push_back(mk('h0225, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 1, 0, 'h0020, 'h0000, 1, 5));
        tbl.push_back(mk('h0225, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 1, 1, 'h0000, 'h0020, 0, 0));
        tbl.push_back(mk('h0235, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 1, 0, 'h0010, 'h0020, 0, 0));
        tbl.push_back(mk('h02B5, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 1, 0, 'h0090, 'h0020, 1, 7));
        tbl.push_back(mk('h02B5, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 1, 1, 'h0010, 'h00A0, 0, 0));
        tbl.push_back(mk('h02B5, 'hFFFF, 'hFFFF, 'hFFFF, 0, 'h0020, 1, 0, 'h0010, 'h0080, 0, 0));
        tbl.push_back(mk('h02B5, 'hFFFF, 'hFFFF, 'hFFFF, 0, 'h0080, 1, 0, 'h0010, 'h0000, 1, 4));
        tbl.push_back(mk('h02B5, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 1, 1, 'h0000, 'h0010, 0, 0));
        tbl.push_back(mk('h02B5, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0000, 'h0000, 0, 0));
        // Same-cycle: clear vs edge, ack vs edge, ack without request.
        tbl.push_back(mk('h02F5, 'hFFFF, 'hFFFF, 'hFFFF, 'h0040, 0, 0, 0, 'h0000, 0, 0, 0));
        tbl.push_back(mk('h02B5, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0000, 0, 0, 0));
        tbl.push_back(mk('h02F5, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0040, 0, 1, 6));
        tbl.push_back(mk('h02B5, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 0, 'h0040, 0, 1, 6));
        tbl.push_back(mk('h02F5, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 1, 'h0040, 0, 1, 6));
        tbl.push_back(mk('h02F5, 'hFFFF, 'hFFFF, 'hFFBF, 0, 0, 0, 0, 'h0040, 0, 0, 0));
        tbl.push_back(mk('h02F5, 'hFFFF, 'hFFFF, 'hFFBF, 0, 0, 1, 1, 'h0040, 0, 0, 0));
        tbl.push_back(mk('h02F5, 'hFFFF, 'hFFFF, 'hFFFF, 'h0040, 0, 0, 0, 'h0000, 0, 0, 0));
        // Mask holds ch8 pending; enable drop clears it; re-pend while masked.
        tbl.push_back(mk('h03F5, 'hFFFF, 'hFFFF, 'hFEFF, 0, 0, 0, 0, 'h0100, 0, 0, 0));
        tbl.push_back(mk('h03F5, 'hFFFF, 'hFFFF, 'hFEFF, 0, 0, 0, 0, 'h0100, 0, 0, 0));
        tbl.push_back(mk('h03F5, 'hFFFF, 'hFEFF, 'hFEFF, 0, 0, 0, 0, 'h0000, 0, 0, 0));
        tbl.push_back(mk('h02F5, 'hFFFF, 'hFFFF, 'hFEFF, 0, 0, 0, 0, 'h0000, 0, 0, 0));
        tbl.push_back(mk('h03F5, 'hFFFF, 'hFFFF, 'hFEFF, 0, 0, 0, 0, 'h0100, 0, 0, 0));

        reset = 1'b1;
        drive(tbl[0]);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", -1, 'h0000, 'h0000, 1'b0, 4'd0);

        @(negedge clk);
        reset = 1'b0;
        foreach (tbl[k]) begin
            drive(tbl[k]);
            @(posedge clk);
            #1;
            check_all("vec", k, tbl[k].e_ipr, tbl[k].e_isr, tbl[k].e_irq, tbl[k].e_num);
            @(negedge clk);
        end

        // Unmasking ch8 raises irq without waiting for a clock.
        bus.mask = 'hFFFF;
        #1;
        check_all("unmask", 0, 'h0100, 'h0000, 1'b1, 4'd8);

        // Reset landing while an acknowledge is being presented.
        bus.sei  = 1'b1;
        bus.iack = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check_all("rst_mid_ack", 0, 'h0000, 'h0000, 1'b0, 4'd0);

        @(negedge clk);
        bus.iack = 1'b0;
        bus.sei  = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        check_all("rearm", 0, 'h0000, 'h0000, 1'b0, 4'd0);
        @(negedge clk);
        src = 'h03F4;
        @(posedge clk);
        #1;
        check_all("rearm", 1, 'h0000, 'h0000, 1'b0, 4'd0);
        @(negedge clk);
        src = 'h03F5;
        @(posedge clk);
        #1;
        check_all("rearm", 2, 'h0001, 'h0000, 1'b1, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mfp_irq_ctrl.md
Name: mfp_irq_ctrl

Overview:
Parametrised N-channel MFP-style interrupt controller, successor to the 16-bit pending set/reset flip-flop.
- Per-channel edge-polarity select, enable and mask.
- Software end-of-interrupt (in-service) mode and priority encoding.
- Interrupt-acknowledge handshake.
Sits between raw peripheral interrupt lines (GPIP, timers, USART) and the MFP CPU-interface/vector logic.

Parameters:
CHANNELS, 16, number of interrupt channels N (2..32); channel N-1 has highest priority.
CW, $clog2(CHANNELS), width of channel index output.

Ports:
clk  in  1  system clock (32 MHz domain).
reset  in  1  asynchronous, active-high reset.
src  in  CHANNELS  raw interrupt source levels, synchronous to clk.
edge_pol  in  CHANNELS  per channel: 1 = rising edge active, 0 = falling edge active.
enable  in  CHANNELS  interrupt enable (IER); 0 forces pending bit clear.
mask  in  CHANNELS  interrupt mask (IMR); 0 blocks request, pending bit retained.
clr_pend  in  CHANNELS  per-bit pending clear, level-sensitive (CPU write of 0 to IPR).
clr_isr  in  CHANNELS  per-bit in-service clear, level-sensitive (CPU write of 0 to ISR).
sei  in  1  software end-of-interrupt mode; 0 = automatic EOI.
iack  in  1  interrupt acknowledge strobe, one clk cycle per acknowledge.
irq  out  1  interrupt request, active high.
irq_num  out  CW  index of highest-priority requesting channel.
ipr  out  CHANNELS  pending register.
isr  out  CHANNELS  in-service register.

Behaviour:
- Reset (async): ipr=0, isr=0, src_d=0, armed=0. Outputs: irq=0, irq_num=0.
- First clock after reset release: src_d<=src, armed<=1, no edge detection. This prevents spurious pending on sources already active at reset.
- Edge detect: edge[i] = armed & (src_d[i]!=src[i]) & (src[i]==edge_pol[i]). src_d<=src every clock. A change of edge_pol with a static src counts as no edge.
- ipr[i] next-state priority, highest first:
  - ~enable[i] or clr_pend[i] -> 0.
  - else edge[i] -> 1.
  - else iack hit on i -> 0.
  - else hold.
  - So a new edge coinciding with its own acknowledge is not lost; an explicit CPU clear always wins.
- Latency: ipr bit visible one clk after the cycle in which src shows the active edge.
- Request vector: req = ipr & mask & ~block.
  - sei=1: block[j]=1 for all j <= highest set isr index (higher channels may nest).
  - sei=0: block=0.
- irq = |req; irq_num = index of highest set req bit, 0 if none.
- irq/irq_num are combinational from registered ipr/isr and the mask/sei inputs, so there are no added cycles.
- iack with irq=1 ("hit" on channel k=irq_num at that clock):
  - ipr[k]<=0, subject to the priority list above.
  - if sei=1, isr[k]<=1.
  - iack with irq=0 is ignored; no state change.
- isr[i] next-state:
  - sei=0 -> 0 (all in-service bits cleared, held clear).
  - else clr_isr[i] -> 0.
  - else iack hit on i -> 1.
  - else hold.
  - clr_isr and an ack on the same bit in the same cycle: clear wins.
- Mask change: irq responds in the same cycle (combinational); ipr unaffected.
- Enable drop: pending cleared at next clk; isr unaffected.
- Reset mid-acknowledge: all state cleared immediately; no partial update.
- All channels independent except priority encode/block. CHANNELS not a power of two: unused irq_num codes never produced.

Test Plan:
- Reset release with src=16'h0001, edge_pol=16'hFFFF -> no ipr set; then src[0] 1->0->1 -> ipr=16'h0001 one clk after the rising sample, irq=1, irq_num=0 (mask/enable all ones).
- edge_pol[3]=0, falling edge on src[3] and rising on src[3] -> only the falling edge sets ipr[3]. Same with enable[3]=0 -> ipr stays 0.
- Simultaneous edges ch2 and ch9 -> irq_num=9. iack -> ipr=16'h0004, irq_num=2 the next cycle. iack -> ipr=0, irq=0.
- sei=1: pend ch5, iack -> isr=16'h0020. Pend ch4 -> irq=0 (blocked). Pend ch7 -> irq=1, irq_num=7. clr_isr[5] -> ch4 unblocked once ch7 is acked and in service cleared. Drop sei -> isr=0.
- Same-cycle events:
  - clr_pend[6] with edge on ch6 -> ipr[6]=0.
  - iack on ch6 with a new edge on ch6 -> ipr[6] stays 1.
  - iack with irq=0 -> no change.
- mask[8]=0 with ipr[8]=1 -> irq=0, ipr[8] held. mask[8]=1 -> irq=1 same cycle. Async reset pulse mid-sequence -> ipr=isr=0, irq=0 immediately.
